// File: rtl/ccu_addr_guard.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ccu_addr_guard : per-port AW/AR address-hazard filter in front of the CCU.  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+

package ccu_addr_guard_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 64;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        snoop;
        logic [1:0]        domain;
        logic [1:0]        bar;
    } ax_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [3:0]        resp;
        logic              last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
        logic     wack;
        logic     rack;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

module ccu_addr_guard #(
    parameter int unsigned NoPorts      = 2,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned MaxTrx       = 4,
    parameter bit          CheckRdRd    = 1'b0,
    parameter type         req_t        = ccu_addr_guard_pkg::req_t,
    parameter type         resp_t       = ccu_addr_guard_pkg::resp_t
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  req_t               core_req_i  [NoPorts],
    output resp_t              core_resp_o [NoPorts],
    output req_t               ccu_req_o   [NoPorts],
    input  resp_t              ccu_resp_i  [NoPorts],
    output logic [NoPorts-1:0] aw_stall_o,
    output logic [NoPorts-1:0] ar_stall_o
);

    localparam int unsigned IVL_W  = AxiAddrWidth + 1;
    localparam int unsigned RR_W   = (NoPorts > 1) ? $clog2(NoPorts) : 1;
    localparam int          DIR_AW = 0;
    localparam int          DIR_AR = 1;

    // Request intervals, indexed [port][direction]
    logic [IVL_W-1:0]      ax_start [NoPorts][2];
    logic [IVL_W-1:0]      ax_end   [NoPorts][2];
    logic [AxiIdWidth-1:0] ax_id    [NoPorts][2];
    logic [1:0]            ax_valid [NoPorts];
    logic [1:0]            ax_ready [NoPorts];

    logic [1:0]            pass_raw [NoPorts];
    logic [1:0]            pass     [NoPorts];
    logic                  contest_lost;

    logic [IVL_W-1:0]      tbl_start_q [NoPorts][2][MaxTrx];
    logic [IVL_W-1:0]      tbl_start_d [NoPorts][2][MaxTrx];
    logic [IVL_W-1:0]      tbl_end_q   [NoPorts][2][MaxTrx];
    logic [IVL_W-1:0]      tbl_end_d   [NoPorts][2][MaxTrx];
    logic [AxiIdWidth-1:0] tbl_id_q    [NoPorts][2][MaxTrx];
    logic [AxiIdWidth-1:0] tbl_id_d    [NoPorts][2][MaxTrx];
    logic [MaxTrx-1:0]     tbl_valid_q [NoPorts][2];
    logic [MaxTrx-1:0]     tbl_valid_d [NoPorts][2];

    logic [1:0]            lock_q [NoPorts];
    logic [1:0]            lock_d [NoPorts];
    logic [RR_W-1:0]       rr_q;
    logic [RR_W-1:0]       rr_d;

    function automatic logic [IVL_W-1:0] ivl_start(input logic [AxiAddrWidth-1:0] addr,
                                                   input logic [2:0]              size);
        logic [AxiAddrWidth-1:0] mask;
        mask = {AxiAddrWidth{1'b1}} << size;
        return {1'b0, addr & mask};
    endfunction

    // End is exclusive and one bit wider than the address so the top page never wraps
    function automatic logic [IVL_W-1:0] ivl_end(input logic [IVL_W-1:0] start,
                                                 input logic [7:0]       len,
                                                 input logic [2:0]       size);
        return start + ((IVL_W'(len) + IVL_W'(1)) << size);
    endfunction

    function automatic logic overlaps(input logic [IVL_W-1:0] a_s, input logic [IVL_W-1:0] a_e,
                                      input logic [IVL_W-1:0] b_s, input logic [IVL_W-1:0] b_e);
        return (a_s < b_e) && (b_s < a_e);
    endfunction

    function automatic logic is_hazard(input int d, input int e);
        return (d == DIR_AW) || (e == DIR_AW) || CheckRdRd;
    endfunction

    function automatic int unsigned prio_of(input int unsigned port, input logic [RR_W-1:0] rr);
        return (port + NoPorts - 32'(rr)) % NoPorts;
    endfunction

    always_comb begin
        for (int p = 0; p < NoPorts; p++) begin
            ax_valid[p][DIR_AW] = core_req_i[p].aw_valid;
            ax_valid[p][DIR_AR] = core_req_i[p].ar_valid;
            ax_ready[p][DIR_AW] = ccu_resp_i[p].aw_ready;
            ax_ready[p][DIR_AR] = ccu_resp_i[p].ar_ready;
            ax_id[p][DIR_AW]    = core_req_i[p].aw.id[AxiIdWidth-1:0];
            ax_id[p][DIR_AR]    = core_req_i[p].ar.id[AxiIdWidth-1:0];
            ax_start[p][DIR_AW] = ivl_start(core_req_i[p].aw.addr[AxiAddrWidth-1:0],
                                            core_req_i[p].aw.size);
            ax_start[p][DIR_AR] = ivl_start(core_req_i[p].ar.addr[AxiAddrWidth-1:0],
                                            core_req_i[p].ar.size);
            ax_end[p][DIR_AW]   = ivl_end(ax_start[p][DIR_AW], core_req_i[p].aw.len,
                                          core_req_i[p].aw.size);
            ax_end[p][DIR_AR]   = ivl_end(ax_start[p][DIR_AR], core_req_i[p].ar.len,
                                          core_req_i[p].ar.size);
        end
    end

    // A locked request bypasses every check; everything else must clear capacity,
    // in-flight entries, locked peers and the same-cycle priority contest.
    always_comb begin
        contest_lost = 1'b0;
        for (int p = 0; p < NoPorts; p++) begin
            pass_raw[p] = 2'b11;
            for (int d = 0; d < 2; d++) begin
                if (!lock_q[p][d]) begin
                    if (&tbl_valid_q[p][d]) begin
                        pass_raw[p][d] = 1'b0;
                    end
                    for (int q = 0; q < NoPorts; q++) begin
                        if (q != p) begin
                            for (int e = 0; e < 2; e++) begin
                                if (is_hazard(d, e)) begin
                                    for (int k = 0; k < MaxTrx; k++) begin
                                        if (tbl_valid_q[q][e][k] &&
                                            overlaps(ax_start[p][d], ax_end[p][d],
                                                     tbl_start_q[q][e][k], tbl_end_q[q][e][k])) begin
                                            pass_raw[p][d] = 1'b0;
                                        end
                                    end
                                    if (ax_valid[q][e] &&
                                        overlaps(ax_start[p][d], ax_end[p][d],
                                                 ax_start[q][e], ax_end[q][e])) begin
                                        if (lock_q[q][e]) begin
                                            pass_raw[p][d] = 1'b0;
                                        end else if (ax_valid[p][d] &&
                                                     (prio_of(q, rr_q) < prio_of(p, rr_q))) begin
                                            pass_raw[p][d] = 1'b0;
                                            contest_lost   = 1'b1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
            end
            pass[p] = pass_raw[p] & {2{rst_ni}};
        end
    end

    always_comb begin
        aw_stall_o = '0;
        ar_stall_o = '0;
        for (int p = 0; p < NoPorts; p++) begin
            ccu_req_o[p]            = core_req_i[p];
            core_resp_o[p]          = ccu_resp_i[p];
            ccu_req_o[p].aw_valid   = core_req_i[p].aw_valid & pass[p][DIR_AW];
            ccu_req_o[p].ar_valid   = core_req_i[p].ar_valid & pass[p][DIR_AR];
            core_resp_o[p].aw_ready = ccu_resp_i[p].aw_ready & pass[p][DIR_AW];
            core_resp_o[p].ar_ready = ccu_resp_i[p].ar_ready & pass[p][DIR_AR];
            aw_stall_o[p]           = core_req_i[p].aw_valid & ~pass_raw[p][DIR_AW] & rst_ni;
            ar_stall_o[p]           = core_req_i[p].ar_valid & ~pass_raw[p][DIR_AR] & rst_ni;
        end
    end

    // Table update: retire the oldest ID match (compacting younger entries), then append
    always_comb begin
        logic                  hs;
        logic                  ret_en;
        logic [AxiIdWidth-1:0] ret_id;
        logic                  ret_hit;
        int                    ret_idx;
        logic                  pushed;
        hs          = 1'b0;
        ret_en      = 1'b0;
        ret_id      = '0;
        ret_hit     = 1'b0;
        ret_idx     = 0;
        pushed      = 1'b0;
        tbl_start_d = tbl_start_q;
        tbl_end_d   = tbl_end_q;
        tbl_id_d    = tbl_id_q;
        tbl_valid_d = tbl_valid_q;
        for (int p = 0; p < NoPorts; p++) begin
            lock_d[p] = 2'b00;
            for (int d = 0; d < 2; d++) begin
                hs           = ax_valid[p][d] & pass[p][d] & ax_ready[p][d];
                lock_d[p][d] = ax_valid[p][d] & pass[p][d] & ~ax_ready[p][d];
                if (d == DIR_AW) begin
                    ret_en = ccu_resp_i[p].b_valid & core_req_i[p].b_ready;
                    ret_id = ccu_resp_i[p].b.id[AxiIdWidth-1:0];
                end else begin
                    ret_en = ccu_resp_i[p].r_valid & core_req_i[p].r_ready & ccu_resp_i[p].r.last;
                    ret_id = ccu_resp_i[p].r.id[AxiIdWidth-1:0];
                end
                ret_hit = 1'b0;
                ret_idx = 0;
                for (int k = 0; k < MaxTrx; k++) begin
                    if (ret_en && !ret_hit && tbl_valid_q[p][d][k] && (tbl_id_q[p][d][k] == ret_id)) begin
                        ret_hit = 1'b1;
                        ret_idx = k;
                    end
                end
                for (int k = 0; k < MaxTrx; k++) begin
                    if (ret_hit && (k >= ret_idx)) begin
                        if (k == MaxTrx - 1) begin
                            tbl_valid_d[p][d][k] = 1'b0;
                        end else begin
                            tbl_start_d[p][d][k] = tbl_start_q[p][d][(k + 1) % MaxTrx];
                            tbl_end_d[p][d][k]   = tbl_end_q[p][d][(k + 1) % MaxTrx];
                            tbl_id_d[p][d][k]    = tbl_id_q[p][d][(k + 1) % MaxTrx];
                            tbl_valid_d[p][d][k] = tbl_valid_q[p][d][(k + 1) % MaxTrx];
                        end
                    end
                end
                pushed = 1'b0;
                for (int k = 0; k < MaxTrx; k++) begin
                    if (hs && !pushed && !tbl_valid_d[p][d][k]) begin
                        tbl_start_d[p][d][k] = ax_start[p][d];
                        tbl_end_d[p][d][k]   = ax_end[p][d];
                        tbl_id_d[p][d][k]    = ax_id[p][d];
                        tbl_valid_d[p][d][k] = 1'b1;
                        pushed               = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (contest_lost) begin
            rr_d = (rr_q == RR_W'(NoPorts - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int p = 0; p < NoPorts; p++) begin
                tbl_valid_q[p][DIR_AW] <= '0;
                tbl_valid_q[p][DIR_AR] <= '0;
                lock_q[p]              <= 2'b00;
            end
            rr_q <= '0;
        end else begin
            tbl_valid_q <= tbl_valid_d;
            lock_q      <= lock_d;
            rr_q        <= rr_d;
        end
    end

    // Payload storage is qualified by tbl_valid_q and needs no reset
    always_ff @(posedge clk_i) begin
        tbl_start_q <= tbl_start_d;
        tbl_end_q   <= tbl_end_d;
        tbl_id_q    <= tbl_id_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_ccu_addr_guard.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ccu_addr_guard : directed checks of ccu_addr_guard (two configurations).  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+

module tb_ccu_addr_guard;
    import ccu_addr_guard_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A: MaxTrx=4, CheckRdRd=0.  Instance B: MaxTrx=2, CheckRdRd=1.
    req_t       core_req_a  [2];
    resp_t      core_resp_a [2];
    req_t       ccu_req_a   [2];
    resp_t      ccu_resp_a  [2];
    logic [1:0] aw_stall_a, ar_stall_a;
    req_t       core_req_b  [2];
    resp_t      core_resp_b [2];
    req_t       ccu_req_b   [2];
    resp_t      ccu_resp_b  [2];
    logic [1:0] aw_stall_b, ar_stall_b;

    int checks   = 0;
    int failures = 0;

    ccu_addr_guard #(.NoPorts(2), .AxiAddrWidth(64), .AxiIdWidth(4), .MaxTrx(4), .CheckRdRd(1'b0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(core_req_a), .core_resp_o(core_resp_a),
        .ccu_req_o(ccu_req_a), .ccu_resp_i(ccu_resp_a),
        .aw_stall_o(aw_stall_a), .ar_stall_o(ar_stall_a)
    );

    ccu_addr_guard #(.NoPorts(2), .AxiAddrWidth(64), .AxiIdWidth(4), .MaxTrx(2), .CheckRdRd(1'b1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(core_req_b), .core_resp_o(core_resp_b),
        .ccu_req_o(ccu_req_b), .ccu_resp_i(ccu_resp_b),
        .aw_stall_o(aw_stall_b), .ar_stall_o(ar_stall_b)
    );

    typedef struct {
        string       name;
        int          cha;
        logic [63:0] addra;
        logic [7:0]  lena;
        logic [2:0]  sizea;
        int          chb;
        logic [63:0] addrb;
        logic [7:0]  lenb;
        logic [2:0]  sizeb;
        logic [3:0]  exp_stall;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_all();
        for (int p = 0; p < 2; p++) begin
            core_req_a[p] = '0;
            ccu_resp_a[p] = '0;
            core_req_b[p] = '0;
            ccu_resp_b[p] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Channel numbering: 0=P0 AW, 1=P0 AR, 2=P1 AW, 3=P1 AR
    task automatic set_ax(input bit on_b, input int ch, input logic [63:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [3:0] id);
        int p;
        p = ch / 2;
        if (!on_b) begin
            if (ch % 2 == 0) begin
                core_req_a[p].aw_valid = 1'b1;
                core_req_a[p].aw.addr  = addr;
                core_req_a[p].aw.len   = len;
                core_req_a[p].aw.size  = size;
                core_req_a[p].aw.id    = id;
            end else begin
                core_req_a[p].ar_valid = 1'b1;
                core_req_a[p].ar.addr  = addr;
                core_req_a[p].ar.len   = len;
                core_req_a[p].ar.size  = size;
                core_req_a[p].ar.id    = id;
            end
        end else begin
            if (ch % 2 == 0) begin
                core_req_b[p].aw_valid = 1'b1;
                core_req_b[p].aw.addr  = addr;
                core_req_b[p].aw.len   = len;
                core_req_b[p].aw.size  = size;
                core_req_b[p].aw.id    = id;
            end else begin
                core_req_b[p].ar_valid = 1'b1;
                core_req_b[p].ar.addr  = addr;
                core_req_b[p].ar.len   = len;
                core_req_b[p].ar.size  = size;
                core_req_b[p].ar.id    = id;
            end
        end
    endtask

    task automatic lock_seq(input int holder);
        int other;
        other = 1 - holder;
        do_reset();
        set_ax(1'b0, holder * 2, 64'h7000, 8'd0, 3'd3, 4'd1);
        #1;
        chk($sformatf("lock%0d_first_valid", holder), 64'(ccu_req_a[holder].aw_valid), 64'd1);
        tick();
        set_ax(1'b0, other * 2, 64'h7000, 8'd0, 3'd3, 4'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("lock%0d_hold_valid_%0d", holder, i), 64'(ccu_req_a[holder].aw_valid), 64'd1);
            chk($sformatf("lock%0d_peer_stall_%0d", holder, i), 64'(aw_stall_a[other]), 64'd1);
            tick();
        end
        ccu_resp_a[holder].aw_ready = 1'b1;
        #1;
        chk($sformatf("lock%0d_handshake_ready", holder), 64'(core_resp_a[holder].aw_ready), 64'd1);
        tick();
        ccu_resp_a[holder].aw_ready = 1'b0;
        core_req_a[holder].aw_valid = 1'b0;
        #1;
        chk($sformatf("lock%0d_peer_vs_entry", holder), 64'(aw_stall_a[other]), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        clr_all();

        vecs[0]  = '{"touch_ww",    0, 64'h1000, 8'd3,   3'd3, 2, 64'h1020, 8'd0, 3'd3, 4'b0000};
        vecs[1]  = '{"overlap_ww",  0, 64'h1000, 8'd3,   3'd3, 2, 64'h1018, 8'd0, 3'd3, 4'b0100};
        vecs[2]  = '{"rd_rd",       1, 64'h2000, 8'd0,   3'd2, 3, 64'h2000, 8'd0, 3'd2, 4'b0000};
        vecs[3]  = '{"rd_wr",       1, 64'h2000, 8'd0,   3'd2, 2, 64'h2002, 8'd0, 3'd0, 4'b0100};
        vecs[4]  = '{"same_port",   0, 64'h4000, 8'd0,   3'd3, 1, 64'h4000, 8'd0, 3'd3, 4'b0000};
        vecs[5]  = '{"align",       0, 64'h5007, 8'd0,   3'd3, 3, 64'h5000, 8'd0, 3'd0, 4'b1000};
        vecs[6]  = '{"touch_rw",    1, 64'h6000, 8'd1,   3'd2, 2, 64'h6008, 8'd0, 3'd2, 4'b0000};
        vecs[7]  = '{"long_burst",  0, 64'h0,    8'd255, 3'd6, 3, 64'h3FC0, 8'd0, 3'd6, 4'b1000};
        vecs[8]  = '{"top_no_wrap", 0, 64'hFFFF_FFFF_FFFF_FFF8, 8'd0, 3'd3,
                                    3, 64'hFFFF_FFFF_FFFF_FFFC, 8'd0, 3'd2, 4'b1000};
        vecs[9]  = '{"p0rd_p1wr",   2, 64'hA000, 8'd0,   3'd3, 1, 64'hA004, 8'd0, 3'd2, 4'b0100};
        vecs[10] = '{"adjacent",    1, 64'hB000, 8'd0,   3'd3, 2, 64'hB008, 8'd3, 3'd0, 4'b0000};

        // Single-cycle overlap/priority vectors, each from a clean reset (rr_q=0)
        for (int i = 0; i < 11; i++) begin
            logic [3:0] vmask;
            logic [3:0] act_stall;
            logic [3:0] act_valid;
            do_reset();
            set_ax(1'b0, vecs[i].cha, vecs[i].addra, vecs[i].lena, vecs[i].sizea, 4'd1);
            set_ax(1'b0, vecs[i].chb, vecs[i].addrb, vecs[i].lenb, vecs[i].sizeb, 4'd2);
            vmask = 4'b0000;
            vmask[vecs[i].cha] = 1'b1;
            vmask[vecs[i].chb] = 1'b1;
            #1;
            act_stall = {ar_stall_a[1], aw_stall_a[1], ar_stall_a[0], aw_stall_a[0]};
            act_valid = {ccu_req_a[1].ar_valid, ccu_req_a[1].aw_valid,
                         ccu_req_a[0].ar_valid, ccu_req_a[0].aw_valid};
            chk({vecs[i].name, "_stall"}, 64'(act_stall), 64'(vecs[i].exp_stall));
            chk({vecs[i].name, "_valid"}, 64'(act_valid), 64'(vmask & ~vecs[i].exp_stall));
        end

        // Reset state: with all inputs idle nothing is issued or stalled
        do_reset();
        #1;
        chk("reset_idle", 64'({aw_stall_a, ar_stall_a, ccu_req_a[0].aw_valid, ccu_req_a[1].ar_valid}), 64'd0);

        // Write in flight blocks an overlapping read until its B with matching ID
        set_ax(1'b0, 0, 64'h1000, 8'd3, 3'd3, 4'd5);
        ccu_resp_a[0].aw_ready = 1'b1;
        #1;
        chk("wr_hs_ready", 64'(core_resp_a[0].aw_ready), 64'd1);
        tick();
        clr_all();
        set_ax(1'b0, 3, 64'h1010, 8'd0, 3'd3, 4'd0);
        #1;
        chk("rd_blocked", 64'(ar_stall_a[1]), 64'd1);
        chk("rd_blocked_valid", 64'(ccu_req_a[1].ar_valid), 64'd0);
        tick();
        ccu_resp_a[0].b_valid = 1'b1;
        ccu_resp_a[0].b.id    = 4'd3;
        core_req_a[0].b_ready = 1'b1;
        #1;
        chk("b_passthrough", 64'(core_resp_a[0].b_valid), 64'd1);
        tick();
        ccu_resp_a[0].b.id = 4'd5;
        #1;
        chk("rd_after_wrong_id", 64'(ar_stall_a[1]), 64'd1);
        tick();
        ccu_resp_a[0].b_valid = 1'b0;
        core_req_a[0].b_ready = 1'b0;
        #1;
        chk("rd_after_b", 64'(ar_stall_a[1]), 64'd0);
        chk("rd_after_b_valid", 64'(ccu_req_a[1].ar_valid), 64'd1);

        // Read-read with one read in flight: stalls only when CheckRdRd=1
        do_reset();
        set_ax(1'b0, 1, 64'h2000, 8'd0, 3'd3, 4'd1);
        set_ax(1'b1, 1, 64'h2000, 8'd0, 3'd3, 4'd1);
        ccu_resp_a[0].ar_ready = 1'b1;
        ccu_resp_b[0].ar_ready = 1'b1;
        tick();
        clr_all();
        set_ax(1'b0, 3, 64'h2000, 8'd0, 3'd3, 4'd2);
        set_ax(1'b1, 3, 64'h2000, 8'd0, 3'd3, 4'd2);
        #1;
        chk("rdrd_off", 64'(ar_stall_a[1]), 64'd0);
        chk("rdrd_on", 64'(ar_stall_b[1]), 64'd1);

        // Round-robin: P0 wins at rr=0, P1 wins the rematch
        do_reset();
        set_ax(1'b0, 0, 64'h3000, 8'd0, 3'd3, 4'd1);
        set_ax(1'b0, 2, 64'h3000, 8'd0, 3'd3, 4'd2);
        ccu_resp_a[0].aw_ready = 1'b1;
        ccu_resp_a[1].aw_ready = 1'b1;
        #1;
        chk("rr0_valid", 64'({ccu_req_a[1].aw_valid, ccu_req_a[0].aw_valid}), 64'b01);
        chk("rr0_stall", 64'(aw_stall_a), 64'b10);
        tick();
        clr_all();
        ccu_resp_a[0].b_valid = 1'b1;
        ccu_resp_a[0].b.id    = 4'd1;
        core_req_a[0].b_ready = 1'b1;
        tick();
        clr_all();
        set_ax(1'b0, 0, 64'h3000, 8'd0, 3'd3, 4'd1);
        set_ax(1'b0, 2, 64'h3000, 8'd0, 3'd3, 4'd2);
        #1;
        chk("rr1_valid", 64'({ccu_req_a[1].aw_valid, ccu_req_a[0].aw_valid}), 64'b10);
        chk("rr1_stall", 64'(aw_stall_a), 64'b01);

        // Locked request holds its valid while the CCU back-pressures
        lock_seq(0);
        lock_seq(1);

        // Capacity on instance B (MaxTrx=2) and oldest-first retirement
        do_reset();
        set_ax(1'b1, 0, 64'h8000, 8'd0, 3'd3, 4'd1);
        ccu_resp_b[0].aw_ready = 1'b1;
        #1;
        chk("cap_first", 64'(ccu_req_b[0].aw_valid), 64'd1);
        tick();
        core_req_b[0].aw.addr = 64'h8100;
        #1;
        chk("cap_second", 64'(ccu_req_b[0].aw_valid), 64'd1);
        tick();
        core_req_b[0].aw.addr = 64'h8200;
        #1;
        chk("cap_full", 64'(aw_stall_b[0]), 64'd1);
        chk("cap_full_ready", 64'(core_resp_b[0].aw_ready), 64'd0);
        tick();
        ccu_resp_b[0].b_valid = 1'b1;
        ccu_resp_b[0].b.id    = 4'd1;
        core_req_b[0].b_ready = 1'b1;
        #1;
        chk("cap_full_during_b", 64'(aw_stall_b[0]), 64'd1);
        tick();
        ccu_resp_b[0].b_valid = 1'b0;
        core_req_b[0].b_ready = 1'b0;
        set_ax(1'b1, 3, 64'h8000, 8'd0, 3'd3, 4'd0);
        #1;
        chk("cap_third_passes", 64'(aw_stall_b[0]), 64'd0);
        chk("cap_oldest_freed", 64'(ar_stall_b[1]), 64'd1 - 64'd1);
        core_req_b[1].ar.addr = 64'h8100;
        #1;
        chk("cap_younger_kept", 64'(ar_stall_b[1]), 64'd1);

        // Reset with live entries: everything gated, then conflict gone on release
        do_reset();
        set_ax(1'b0, 0, 64'h9000, 8'd0, 3'd3, 4'd2);
        ccu_resp_a[0].aw_ready = 1'b1;
        tick();
        core_req_a[0].aw.addr = 64'h9100;
        set_ax(1'b0, 3, 64'h9000, 8'd0, 3'd3, 4'd0);
        ccu_resp_a[1].ar_ready = 1'b1;
        #1;
        chk("pre_reset_stall", 64'(ar_stall_a[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("in_reset_gated", 64'({ccu_req_a[0].aw_valid, core_resp_a[0].aw_ready,
                                   ccu_req_a[1].ar_valid, core_resp_a[1].ar_ready,
                                   aw_stall_a, ar_stall_a}), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_reset_stall", 64'(ar_stall_a[1]), 64'd0);
        chk("post_reset_valid", 64'(ccu_req_a[1].ar_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
